// File: rtl/kw_ram_1rws_mask_dff_pkg.sv
// Shared types and helpers for the kw_ram flop-array RAM family.
package kw_ram_1rws_mask_dff_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int unsigned KW_RAM_MIN_DEPTH = 2;

    function automatic int unsigned lane_count(input int unsigned data_width,
                                               input int unsigned lane_width);
        return data_width / lane_width;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < KW_RAM_MIN_DEPTH) ? 1 : unsigned'($clog2(depth));
    endfunction

endpackage

// File: rtl/kw_ram_1rws_mask_dff_if.sv
// Access port bundle for the single-port masked flop RAM.
interface kw_ram_1rws_mask_dff_if
    import kw_ram_1rws_mask_dff_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned LANE_WIDTH = 8
);
    localparam int unsigned LANES  = lane_count(DATA_WIDTH, LANE_WIDTH);
    localparam int unsigned ADDR_W = addr_width(DEPTH);

    logic                  cs_n;
    logic                  we_n;
    logic [LANES-1:0]      wmask_n;
    logic [ADDR_W-1:0]     rw_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  init_done;

    modport master (
        output cs_n, we_n, wmask_n, rw_addr, data_in,
        input  data_out, data_valid, init_done
    );

    modport slave (
        input  cs_n, we_n, wmask_n, rw_addr, data_in,
        output data_out, data_valid, init_done
    );

endinterface

// File: rtl/kw_ram_1rws_mask_dff_init_seq.sv
// Post-reset init sweep: walks every address once, then parks in READY.
//   state | meaning
//   INIT  | writing init value to sweep_addr, one address per cycle
//   READY | sweep finished, array open for access (left only via reset)
module kw_ram_1rws_mask_dff_init_seq
    import kw_ram_1rws_mask_dff_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = addr_width(DEPTH)
)(
    input  logic              clock,
    input  logic              reset_n,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              init_done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= INIT;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sweep_we = 1'b0;
        case (state_q)
            INIT: begin
                sweep_we = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = READY;
                    addr_d  = '0;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign sweep_addr = addr_q;
    assign init_done  = (state_q == READY);

endmodule

// File: rtl/kw_ram_1rws_mask_dff.sv
// Single-port flop RAM with per-lane write mask, read-valid strobe and init sweep.
// Define KW_RAM_1RWS_OUT_REG_EN to add a second output register (read latency 2).
module kw_ram_1rws_mask_dff
    import kw_ram_1rws_mask_dff_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 256,
    parameter int unsigned          DEPTH      = 32,
    parameter int unsigned          LANE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
)(
    input  logic                  clock,
    input  logic                  reset_n,
    kw_ram_1rws_mask_dff_if.slave bus
);
    localparam int unsigned LANES  = lane_count(DATA_WIDTH, LANE_WIDTH);
    localparam int unsigned ADDR_W = addr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep_we;
    logic [ADDR_W-1:0]     sweep_addr;
    logic                  init_done;
    logic                  addr_ok;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    kw_ram_1rws_mask_dff_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .init_done  (init_done)
    );

    // Only matters for non-power-of-two depths; otherwise always true.
    assign addr_ok = (32'(bus.rw_addr) < DEPTH);
    assign wr_fire = init_done && !bus.cs_n && !bus.we_n && addr_ok;
    assign rd_fire = init_done && !bus.cs_n && bus.we_n;

    always_ff @(posedge clock) begin
        if (sweep_we) begin
            mem[sweep_addr] <= INIT_VALUE;
        end else if (wr_fire) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (!bus.wmask_n[i]) begin
                    mem[bus.rw_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                        bus.data_in[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= addr_ok ? mem[bus.rw_addr] : '0;
            end
        end
    end

`ifdef KW_RAM_1RWS_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    // Second stage only loads on a valid read so data_out still holds across writes/idles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_data_q <= rd_data_q;
            end
        end
    end

    assign bus.data_out   = out_data_q;
    assign bus.data_valid = out_valid_q;
`else
    assign bus.data_out   = rd_data_q;
    assign bus.data_valid = rd_valid_q;
`endif

    assign bus.init_done = init_done;

endmodule

// File: tb/tb_kw_ram_1rws_mask_dff.sv
// Directed self-checking bench for kw_ram_1rws_mask_dff (both output-latency builds).
module tb_kw_ram_1rws_mask_dff;

    localparam int unsigned DW    = 256;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned LW    = 8;
    localparam logic [DW-1:0] INIT_V = {32{8'hA5}};
`ifdef KW_RAM_1RWS_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    always #5 clock = ~clock;

    kw_ram_1rws_mask_dff_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LANE_WIDTH(LW)) bus ();
    kw_ram_1rws_mask_dff_if #(.DATA_WIDTH(16), .DEPTH(5), .LANE_WIDTH(8)) sbus ();

    kw_ram_1rws_mask_dff #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .LANE_WIDTH (LW),
        .INIT_VALUE (INIT_V)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    kw_ram_1rws_mask_dff #(
        .DATA_WIDTH (16),
        .DEPTH      (5),
        .LANE_WIDTH (8),
        .INIT_VALUE (16'h5A5A)
    ) dut_small (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (sbus)
    );

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got=running required=done");
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Passive wait for the sweep; returns cycle count and whether outputs misbehaved.
    task automatic run_sweep(output int cycles, output bit valid_seen, output bit out_nonzero);
        cycles      = 0;
        valid_seen  = 1'b0;
        out_nonzero = 1'b0;
        while (bus.init_done !== 1'b1 && cycles < 64) begin
            @(negedge clock);
            cycles++;
            if (bus.data_valid !== 1'b0) valid_seen = 1'b1;
            if (bus.data_out !== '0) out_nonzero = 1'b1;
        end
    endtask

    task automatic do_read(input logic [4:0] a);
        bus.cs_n    = 1'b0;
        bus.we_n    = 1'b1;
        bus.wmask_n = '0;
        bus.rw_addr = a;
        @(negedge clock);
        bus.cs_n = 1'b1;
        repeat (LAT - 1) @(negedge clock);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [DW-1:0] d, input logic [31:0] m);
        bus.cs_n    = 1'b0;
        bus.we_n    = 1'b0;
        bus.wmask_n = m;
        bus.rw_addr = a;
        bus.data_in = d;
        @(negedge clock);
        bus.cs_n = 1'b1;
        bus.we_n = 1'b1;
    endtask

    task automatic s_read(input logic [2:0] a);
        sbus.cs_n    = 1'b0;
        sbus.we_n    = 1'b1;
        sbus.rw_addr = a;
        @(negedge clock);
        sbus.cs_n = 1'b1;
        repeat (LAT - 1) @(negedge clock);
    endtask

    task automatic s_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] m);
        sbus.cs_n    = 1'b0;
        sbus.we_n    = 1'b0;
        sbus.wmask_n = m;
        sbus.rw_addr = a;
        sbus.data_in = d;
        @(negedge clock);
        sbus.cs_n = 1'b1;
        sbus.we_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (bus.data_out !== '0) begin
            bad++;
            $display("FAIL reset_data_out got=%h exp=0", bus.data_out);
        end
        total++;
        if (bus.data_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_data_valid got=%b exp=0", bus.data_valid);
        end
        total++;
        if (bus.init_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_init_done got=%b exp=0", bus.init_done);
        end
    endtask

    task automatic test_init_sweep();
        int cycles;
        bit vseen, onz;
        apply_reset();
        run_sweep(cycles, vseen, onz);
        total++;
        if (cycles !== 32) begin
            bad++;
            $display("FAIL init_cycles got=%0d exp=32", cycles);
        end
        total++;
        if (vseen !== 1'b0) begin
            bad++;
            $display("FAIL init_valid_quiet got=%b exp=0", vseen);
        end
        total++;
        if (onz !== 1'b0) begin
            bad++;
            $display("FAIL init_data_out_zero got=%b exp=0", onz);
        end
        for (int a = 0; a < 32; a++) begin
            do_read(5'(a));
            total++;
            if (bus.data_out !== INIT_V) begin
                bad++;
                $display("FAIL init_read addr=%0d got=%h exp=%h", a, bus.data_out, INIT_V);
            end
            total++;
            if (bus.data_valid !== 1'b1) begin
                bad++;
                $display("FAIL init_read_valid addr=%0d got=%b exp=1", a, bus.data_valid);
            end
        end
    endtask

    task automatic test_masked_write();
        logic [DW-1:0] exp5, exp9;
        exp5 = {{28{8'hA5}}, {4{8'hFF}}};
        exp9 = {{16{8'h3C}}, {16{8'hA5}}};
        do_write(5'd5, {DW{1'b1}}, 32'hFFFF_FFF0);
        do_write(5'd9, {32{8'h3C}}, 32'h0000_FFFF);
        do_read(5'd5);
        total++;
        if (bus.data_out !== exp5) begin
            bad++;
            $display("FAIL mask_addr5 got=%h exp=%h", bus.data_out, exp5);
        end
        do_read(5'd9);
        total++;
        if (bus.data_out !== exp9) begin
            bad++;
            $display("FAIL mask_addr9 got=%h exp=%h", bus.data_out, exp9);
        end
        do_read(5'd6);
        total++;
        if (bus.data_out !== INIT_V) begin
            bad++;
            $display("FAIL mask_neighbor6 got=%h exp=%h", bus.data_out, INIT_V);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] sd [1:4];
        logic          sv [1:4];
        bus.cs_n    = 1'b0;
        bus.we_n    = 1'b0;
        bus.wmask_n = '0;
        bus.rw_addr = 5'd7;
        bus.data_in = 256'h1234;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clock);
            sd[j] = bus.data_out;
            sv[j] = bus.data_valid;
            if (j == 1) bus.we_n = 1'b1;
            if (j == 2) begin
                bus.we_n    = 1'b0;
                bus.data_in = 256'h5678;
            end
            if (j == 3) bus.cs_n = 1'b1;
        end
        for (int j = 1 + LAT; j <= 4; j++) begin
            total++;
            if (sd[j] !== 256'h1234) begin
                bad++;
                $display("FAIL b2b_data sample=%0d got=%h exp=1234", j, sd[j]);
            end
        end
        for (int j = 2; j <= 4; j++) begin
            total++;
            if (sv[j] !== (j == 1 + LAT)) begin
                bad++;
                $display("FAIL b2b_valid sample=%0d got=%b exp=%b", j, sv[j], (j == 1 + LAT));
            end
        end
        do_read(5'd7);
        total++;
        if (bus.data_out !== 256'h5678) begin
            bad++;
            $display("FAIL b2b_rewrite got=%h exp=5678", bus.data_out);
        end
    endtask

    task automatic test_interleave();
        logic [DW-1:0] exp5, w6;
        logic [DW-1:0] sd [1:5];
        logic          sv [1:5];
        exp5 = {{28{8'hA5}}, {4{8'hFF}}};
        w6   = {8{32'hDEAD_BEEF}};
        bus.cs_n    = 1'b0;
        bus.we_n    = 1'b1;
        bus.wmask_n = '0;
        bus.rw_addr = 5'd5;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clock);
            sd[j] = bus.data_out;
            sv[j] = bus.data_valid;
            if (j == 1) begin
                bus.we_n    = 1'b0;
                bus.rw_addr = 5'd6;
                bus.data_in = w6;
            end
            if (j == 2) bus.we_n = 1'b1;
            if (j == 3) bus.cs_n = 1'b1;
        end
        for (int j = 1; j <= 5; j++) begin
            total++;
            if (sv[j] !== ((j == LAT) || (j == 2 + LAT))) begin
                bad++;
                $display("FAIL ilv_valid sample=%0d got=%b exp=%b", j, sv[j], ((j == LAT) || (j == 2 + LAT)));
            end
        end
        total++;
        if (sd[LAT] !== exp5) begin
            bad++;
            $display("FAIL ilv_read5 got=%h exp=%h", sd[LAT], exp5);
        end
        total++;
        if (sd[LAT + 1] !== exp5) begin
            bad++;
            $display("FAIL ilv_hold5 got=%h exp=%h", sd[LAT + 1], exp5);
        end
        total++;
        if (sd[LAT + 2] !== w6) begin
            bad++;
            $display("FAIL ilv_read6 got=%h exp=%h", sd[LAT + 2], w6);
        end
    endtask

    task automatic test_access_during_init();
        bit vseen;
        vseen = 1'b0;
        apply_reset();
        bus.cs_n    = 1'b0;
        bus.rw_addr = 5'd3;
        bus.data_in = '0;
        bus.wmask_n = '0;
        for (int k = 0; k < 32; k++) begin
            bus.we_n = (k % 2 == 1);
            @(negedge clock);
            if (bus.data_valid !== 1'b0) vseen = 1'b1;
        end
        bus.cs_n = 1'b1;
        bus.we_n = 1'b1;
        total++;
        if (vseen !== 1'b0) begin
            bad++;
            $display("FAIL busy_valid_quiet got=%b exp=0", vseen);
        end
        total++;
        if (bus.init_done !== 1'b1) begin
            bad++;
            $display("FAIL busy_init_done got=%b exp=1", bus.init_done);
        end
        do_read(5'd3);
        total++;
        if (bus.data_out !== INIT_V) begin
            bad++;
            $display("FAIL busy_addr3 got=%h exp=%h", bus.data_out, INIT_V);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cycles;
        bit vseen, onz;
        do_read(5'd0);
        apply_reset();
        total++;
        if (bus.data_out !== '0) begin
            bad++;
            $display("FAIL mid_reset_clears got=%h exp=0", bus.data_out);
        end
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        total++;
        if (bus.init_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_init_done got=%b exp=0", bus.init_done);
        end
        run_sweep(cycles, vseen, onz);
        total++;
        if (cycles !== 32) begin
            bad++;
            $display("FAIL mid_cycles got=%0d exp=32", cycles);
        end
        total++;
        if (onz !== 1'b0 || vseen !== 1'b0) begin
            bad++;
            $display("FAIL mid_outputs_quiet got=%b%b exp=00", onz, vseen);
        end
    endtask

    task automatic test_out_of_range();
        total++;
        if (sbus.init_done !== 1'b1) begin
            bad++;
            $display("FAIL oor_init_done got=%b exp=1", sbus.init_done);
        end
        s_read(3'd4);
        total++;
        if (sbus.data_out !== 16'h5A5A || sbus.data_valid !== 1'b1) begin
            bad++;
            $display("FAIL oor_read4 got=%h/%b exp=5a5a/1", sbus.data_out, sbus.data_valid);
        end
        s_write(3'd6, 16'hFFFF, 2'b00);
        s_write(3'd2, 16'h1234, 2'b10);
        s_read(3'd6);
        total++;
        if (sbus.data_out !== 16'h0000 || sbus.data_valid !== 1'b1) begin
            bad++;
            $display("FAIL oor_read6 got=%h/%b exp=0000/1", sbus.data_out, sbus.data_valid);
        end
        s_read(3'd2);
        total++;
        if (sbus.data_out !== 16'h5A34) begin
            bad++;
            $display("FAIL oor_mask_addr2 got=%h exp=5a34", sbus.data_out);
        end
        s_read(3'd7);
        total++;
        if (sbus.data_out !== 16'h0000 || sbus.data_valid !== 1'b1) begin
            bad++;
            $display("FAIL oor_read7 got=%h/%b exp=0000/1", sbus.data_out, sbus.data_valid);
        end
    endtask

    initial begin
        bus.cs_n     = 1'b1;
        bus.we_n     = 1'b1;
        bus.wmask_n  = '1;
        bus.rw_addr  = '0;
        bus.data_in  = '0;
        sbus.cs_n    = 1'b1;
        sbus.we_n    = 1'b1;
        sbus.wmask_n = '1;
        sbus.rw_addr = '0;
        sbus.data_in = '0;
        test_reset();
        test_init_sweep();
        test_masked_write();
        test_back_to_back();
        test_interleave();
        test_access_during_init();
        test_reset_mid_sweep();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
